mdriver_req_sequencer: RTL and testbench



---
 rtl/mdriver_pkg.sv | 33 +++
 rtl/mdriver_req_sequencer_if.sv | 60 ++++++
 rtl/md_req_fifo.sv | 77 +++++++
 rtl/mdriver_req_sequencer.sv | 162 ++++++++++++++++
 tb/tb_mdriver_req_sequencer.sv | 346 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mdriver_pkg.sv
// -----------------------------------------------------------------------------
// mdriver_pkg
// Shared types for the mdriver request sequencer.
//   seq_state_t : sequencer FSM states
//   md_req_t    : one buffered core request {we, addr, wdata}
//   sat_inc8    : saturating 8-bit increment used by the error counter
// The request entry is sized by MD_ADDR_W / MD_DATA_W. The sequencer's
// ADDR_W / DATA_W parameters must not exceed these widths.
// -----------------------------------------------------------------------------
package mdriver_pkg;

  localparam int MD_ADDR_W = 32;
  localparam int MD_DATA_W = 32;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ISSUE = 3'd1,
    WAIT  = 3'd2,
    DRAIN = 3'd3,
    RESP  = 3'd4
  } seq_state_t;

  typedef struct packed {
    logic                 we;
    logic [MD_ADDR_W-1:0] addr;
    logic [MD_DATA_W-1:0] wdata;
  } md_req_t;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/mdriver_req_sequencer_if.sv
// -----------------------------------------------------------------------------
// mdriver_req_sequencer_if
// Bundles the core request/response channels and the mdriver master-side
// signals of the request sequencer.
//   slave  : the sequencer's view (takes core requests, drives the wrapper)
//   master : the environment's view (core + wrapper side)
// Signals:
//   req_valid/req_ready/req_we/req_addr/req_wdata : core request channel
//   rsp_valid/rsp_ready/rsp_we/rsp_rdata/rsp_err  : core response channel
//   md_exec/md_we/md_addr/md_wdata                : launch towards the wrapper
//   md_rdata/md_fin                               : completion from the wrapper
//   err_count                                     : saturating timeout count
// -----------------------------------------------------------------------------
interface mdriver_req_sequencer_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);

  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;

  logic              rsp_valid;
  logic              rsp_ready;
  logic              rsp_we;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_err;

  logic              md_exec;
  logic              md_we;
  logic [ADDR_W-1:0] md_addr;
  logic [DATA_W-1:0] md_wdata;
  logic [DATA_W-1:0] md_rdata;
  logic              md_fin;

  logic [7:0]        err_count;

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata,
    input  rsp_ready,
    input  md_rdata, md_fin,
    output req_ready,
    output rsp_valid, rsp_we, rsp_rdata, rsp_err,
    output md_exec, md_we, md_addr, md_wdata,
    output err_count
  );

  modport master (
    output req_valid, req_we, req_addr, req_wdata,
    output rsp_ready,
    output md_rdata, md_fin,
    input  req_ready,
    input  rsp_valid, rsp_we, rsp_rdata, rsp_err,
    input  md_exec, md_we, md_addr, md_wdata,
    input  err_count
  );

endinterface

// File: rtl/md_req_fifo.sv
// -----------------------------------------------------------------------------
// md_req_fifo
// Synchronous first-word-fall-through FIFO of md_req_t entries.
// Ports:
//   clk, nreset   : clock, synchronous active-low reset (pointers/count only)
//   push_i        : write push_data_i (ignored when full)
//   push_data_i   : entry to store
//   pop_i         : drop the head entry (ignored when empty)
//   head_o        : current head entry, all-zero while empty
//   empty_o       : no entries held
//   full_o        : DEPTH entries held
// DEPTH must be a power of two so the pointers wrap naturally.
// -----------------------------------------------------------------------------
module md_req_fifo
  import mdriver_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic    clk,
  input  logic    nreset,
  input  logic    push_i,
  input  md_req_t push_data_i,
  input  logic    pop_i,
  output md_req_t head_o,
  output logic    empty_o,
  output logic    full_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  md_req_t          mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push;
  logic             do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  // Storage is never reset, so mask the head while empty to present zeros.
  assign head_o = empty_o ? '0 : mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    // Simultaneous push and pop leaves the count unchanged.
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!nreset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data_i;
  end

endmodule

// File: rtl/mdriver_req_sequencer.sv
// -----------------------------------------------------------------------------
// mdriver_req_sequencer
// Upstream stage of the AXI-lite master wrapper. Buffers core load/store
// requests, launches them one at a time towards the wrapper, waits for its
// fin pulse and returns a response to the core. A watchdog turns a missing
// fin into an error response; the late fin is still awaited (DRAIN) so the
// wrapper is idle before the next launch.
// Ports:
//   clk    : clock
//   nreset : synchronous active-low reset; aborts any transaction in flight
//   bus    : request/response/wrapper signals (slave modport)
// Parameters:
//   ADDR_W, DATA_W : bus widths (<= package entry widths)
//   DEPTH          : request FIFO entries, power of two, >= 2
//   TIMEOUT        : WAIT cycles before an error response, >= 4
// -----------------------------------------------------------------------------
module mdriver_req_sequencer
  import mdriver_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 256
) (
  input logic                    clk,
  input logic                    nreset,
  mdriver_req_sequencer_if.slave bus
);

  localparam int WD_W = $clog2(TIMEOUT);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

  seq_state_t        state_q, state_d;
  logic [WD_W-1:0]   wd_q, wd_d;
  logic              exec_q, exec_d;
  logic              rsp_we_q, rsp_we_d;
  logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
  logic              rsp_err_q, rsp_err_d;
  logic [7:0]        err_count_q, err_count_d;

  md_req_t push_entry;
  md_req_t head;
  logic    fifo_push;
  logic    fifo_pop;
  logic    fifo_empty;
  logic    fifo_full;

  always_comb begin
    push_entry       = '0;
    push_entry.we    = bus.req_we;
    push_entry.addr  = MD_ADDR_W'(bus.req_addr);
    push_entry.wdata = MD_DATA_W'(bus.req_wdata);
  end

  assign fifo_push = bus.req_valid && !fifo_full;

  md_req_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk         (clk),
    .nreset      (nreset),
    .push_i      (fifo_push),
    .push_data_i (push_entry),
    .pop_i       (fifo_pop),
    .head_o      (head),
    .empty_o     (fifo_empty),
    .full_o      (fifo_full)
  );

  // The head is only popped when leaving WAIT/DRAIN, so the wrapper-side
  // fields stay put for the whole transaction (the wrapper selects fin by we).
  assign bus.req_ready = !fifo_full;
  assign bus.md_exec   = exec_q;
  assign bus.md_we     = head.we;
  assign bus.md_addr   = ADDR_W'(head.addr);
  assign bus.md_wdata  = DATA_W'(head.wdata);
  assign bus.rsp_valid = (state_q == RESP);
  assign bus.rsp_we    = rsp_we_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.rsp_err   = rsp_err_q;
  assign bus.err_count = err_count_q;

  always_comb begin
    state_d     = state_q;
    wd_d        = wd_q;
    rsp_we_d    = rsp_we_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    err_count_d = err_count_q;
    fifo_pop    = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (!fifo_empty) state_d = ISSUE;
      end

      ISSUE: begin
        wd_d    = '0;
        state_d = WAIT;
      end

      WAIT: begin
        // fin takes priority over a watchdog expiry in the same cycle.
        if (bus.md_fin) begin
          rsp_we_d    = head.we;
          rsp_rdata_d = head.we ? '0 : bus.md_rdata;
          rsp_err_d   = 1'b0;
          fifo_pop    = 1'b1;
          state_d     = RESP;
        end else if (wd_q == WD_LAST) begin
          rsp_we_d    = head.we;
          rsp_rdata_d = '0;
          rsp_err_d   = 1'b1;
          err_count_d = sat_inc8(err_count_q);
          state_d     = DRAIN;
        end else begin
          wd_d = wd_q + 1'b1;
        end
      end

      DRAIN: begin
        // Late fin: its data is discarded, the error response stands.
        if (bus.md_fin) begin
          fifo_pop = 1'b1;
          state_d  = RESP;
        end
      end

      RESP: begin
        if (bus.rsp_ready) state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    // Launch pulse is registered: high exactly for the single ISSUE cycle.
    exec_d = (state_d == ISSUE);
  end

  always_ff @(posedge clk) begin
    if (!nreset) begin
      state_q     <= IDLE;
      wd_q        <= '0;
      exec_q      <= 1'b0;
      rsp_we_q    <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
      err_count_q <= '0;
    end else begin
      state_q     <= state_d;
      wd_q        <= wd_d;
      exec_q      <= exec_d;
      rsp_we_q    <= rsp_we_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
      err_count_q <= err_count_d;
    end
  end

endmodule

// File: tb/tb_mdriver_req_sequencer.sv
// -----------------------------------------------------------------------------
// tb_mdriver_req_sequencer
// Directed + randomized bench. A behavioural wrapper model answers each
// md_exec with a fin after a chosen delay; requests and expected responses
// are kept in queues (in-order, one outstanding, err when the delay exceeds
// TIMEOUT).
// -----------------------------------------------------------------------------
module tb_mdriver_req_sequencer;
  import mdriver_pkg::*;

  localparam int ADDR_W  = 32;
  localparam int DATA_W  = 32;
  localparam int DEPTH   = 4;
  localparam int TIMEOUT = 256;

  logic clk = 1'b0;
  logic nreset;
  always #5 clk = ~clk;

  mdriver_req_sequencer_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  mdriver_req_sequencer #(
    .ADDR_W  (ADDR_W),
    .DATA_W  (DATA_W),
    .DEPTH   (DEPTH),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk    (clk),
    .nreset (nreset),
    .bus    (bus)
  );

  typedef struct {
    bit                we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } req_m_t;

  typedef struct {
    bit                we;
    logic [DATA_W-1:0] rdata;
    bit                err;
  } rsp_m_t;

  req_m_t req_q[$];
  rsp_m_t rsp_q[$];

  int compared   = 0;
  int mismatched = 0;

  int                exec_cnt       = 0;
  int                exec_busy_viol = 0;
  int                fin_delay      = 5;
  bit                rand_delay     = 1'b0;
  bit                use_fix        = 1'b0;
  logic [DATA_W-1:0] fix_rdata      = '0;
  int                abort_gen      = 0;
  int                stray_gen      = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Wrapper model: one transaction at a time, fin after d cycles.
  initial begin : wrapper
    int                cnt;
    int                d;
    bit                busy;
    bit                have;
    int                abort_seen;
    int                stray_seen;
    bit                unstable;
    logic              cap_we;
    logic [ADDR_W-1:0] cap_addr;
    logic [DATA_W-1:0] cap_wdata;
    logic [DATA_W-1:0] rd;
    req_m_t            r;
    rsp_m_t            e;
    cnt = 0; d = 0; busy = 1'b0; abort_seen = 0; stray_seen = 0;
    unstable = 1'b0; cap_we = 1'b0; cap_addr = '0; cap_wdata = '0;
    bus.md_fin   = 1'b0;
    bus.md_rdata = '0;
    forever begin
      @(posedge clk);
      #1;
      bus.md_fin   = 1'b0;
      bus.md_rdata = $urandom;
      if (abort_seen != abort_gen) begin
        abort_seen = abort_gen;
        busy = 1'b0;
      end
      if (stray_seen != stray_gen) begin
        stray_seen = stray_gen;
        bus.md_fin = 1'b1;
      end else if (!busy) begin
        if (bus.md_exec === 1'b1) begin
          busy = 1'b1; cnt = 0; unstable = 1'b0; exec_cnt++;
          cap_we = bus.md_we; cap_addr = bus.md_addr; cap_wdata = bus.md_wdata;
          d = rand_delay ? int'($urandom_range(1, 8)) : fin_delay;
          have = (req_q.size() > 0);
          chk("issue_pending", have, 1);
          r = '{we: 1'b0, addr: '0, wdata: '0};
          if (have) r = req_q.pop_front();
          chk("issue_we", cap_we, r.we);
          chk("issue_addr", cap_addr, r.addr);
          chk("issue_wdata", cap_wdata, r.wdata);
        end
      end else begin
        cnt++;
        if (bus.md_exec !== 1'b0) exec_busy_viol++;
        if (bus.md_we !== cap_we || bus.md_addr !== cap_addr || bus.md_wdata !== cap_wdata)
          unstable = 1'b1;
        if (cnt == d) begin
          rd = use_fix ? fix_rdata : DATA_W'($urandom);
          bus.md_fin   = 1'b1;
          bus.md_rdata = rd;
          e.we    = cap_we;
          e.err   = (d > TIMEOUT);
          e.rdata = (cap_we || e.err) ? '0 : rd;
          rsp_q.push_back(e);
          chk("hold_stable", unstable, 0);
          busy = 1'b0;
        end
      end
    end
  end

  task automatic push_req(input bit we, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] wd);
    bit accepted;
    bit rdy;
    accepted = 1'b0;
    bus.req_valid = 1'b1;
    bus.req_we    = we;
    bus.req_addr  = a;
    bus.req_wdata = wd;
    for (int i = 0; i < 600; i++) begin
      rdy = bus.req_ready;
      tick();
      if (rdy) begin
        accepted = 1'b1;
        req_q.push_back('{we: we, addr: a, wdata: wd});
        break;
      end
    end
    bus.req_valid = 1'b0;
    chk("push_accept", accepted, 1);
  endtask

  task automatic get_rsp(input string tag);
    bit     got;
    bit     have;
    rsp_m_t e;
    got = 1'b0;
    e = '{we: 1'b0, rdata: '0, err: 1'b0};
    for (int i = 0; i < 400; i++) begin
      if (bus.rsp_valid === 1'b1) begin
        got = 1'b1;
        break;
      end
      tick();
    end
    chk({tag, "_rsp_valid"}, got, 1);
    if (got) begin
      have = (rsp_q.size() > 0);
      chk({tag, "_rsp_expected"}, have, 1);
      if (have) e = rsp_q.pop_front();
      chk({tag, "_rsp_we"}, bus.rsp_we, e.we);
      chk({tag, "_rsp_rdata"}, bus.rsp_rdata, e.rdata);
      chk({tag, "_rsp_err"}, bus.rsp_err, e.err);
      bus.rsp_ready = 1'b1;
      tick();
      bus.rsp_ready = 1'b0;
      chk({tag, "_rsp_drop"}, bus.rsp_valid, 0);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_req_ready"}, bus.req_ready, 1);
    chk({tag, "_rsp_valid"}, bus.rsp_valid, 0);
    chk({tag, "_rsp_we"}, bus.rsp_we, 0);
    chk({tag, "_rsp_rdata"}, bus.rsp_rdata, 0);
    chk({tag, "_rsp_err"}, bus.rsp_err, 0);
    chk({tag, "_md_exec"}, bus.md_exec, 0);
    chk({tag, "_md_we"}, bus.md_we, 0);
    chk({tag, "_md_addr"}, bus.md_addr, 0);
    chk({tag, "_md_wdata"}, bus.md_wdata, 0);
    chk({tag, "_err_count"}, bus.err_count, 0);
  endtask

  initial begin : watchdog
    #1000000;
    $display("FAIL global_timeout observed=running required=finished");
    $fatal(1, "bench time limit reached");
  end

  initial begin : main
    int                base;
    int                err_model;
    bit                seen;
    logic [DATA_W-1:0] held;
    err_model = 0;
    nreset        = 1'b0;
    bus.req_valid = 1'b0;
    bus.req_we    = 1'b0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    bus.rsp_ready = 1'b0;
    tick(); tick(); tick();
    chk_reset_vals("reset");
    nreset = 1'b1;
    tick();

    // Single read: exec exactly one cycle, fin 5 cycles after exec.
    fin_delay = 5; use_fix = 1'b1; fix_rdata = 32'hDEADBEEF;
    push_req(1'b0, 32'h10, 32'h0);
    chk("rd_exec_idle", bus.md_exec, 0);
    chk("rd_head_addr", bus.md_addr, 32'h10);
    tick();
    chk("rd_exec_pulse", bus.md_exec, 1);
    tick();
    chk("rd_exec_low", bus.md_exec, 0);
    repeat (4) tick();
    chk("rd_rsp_not_yet", bus.rsp_valid, 0);
    tick();
    chk("rd_rsp_latency", bus.rsp_valid, 1);
    chk("rd_rdata_const", bus.rsp_rdata, 32'hDEADBEEF);
    get_rsp("rd");
    use_fix = 1'b0;

    // Single write: fields stable through WAIT, rdata forced to 0.
    push_req(1'b1, 32'h20, 32'h12345678);
    tick(); tick(); tick();
    chk("wr_md_we", bus.md_we, 1);
    chk("wr_md_addr", bus.md_addr, 32'h20);
    chk("wr_md_wdata", bus.md_wdata, 32'h12345678);
    get_rsp("wr");
    chk("wr_rdata_zero", bus.rsp_rdata, 0);

    // Back-pressure: 4 pushes fill the FIFO; response held with rsp_ready=0.
    tick();
    base = exec_cnt;
    fin_delay = 5;
    for (int i = 0; i < 4; i++) push_req(1'($urandom), $urandom, $urandom);
    chk("bp_full", bus.req_ready, 0);
    repeat (12) tick();
    chk("bp_rsp_held", bus.rsp_valid, 1);
    chk("bp_ready_back", bus.req_ready, 1);
    chk("bp_one_exec", exec_cnt - base, 1);
    held = bus.rsp_rdata;
    repeat (3) tick();
    chk("bp_rdata_stable", bus.rsp_rdata, held);
    fork
      begin
        for (int i = 0; i < 2; i++) push_req(1'($urandom), $urandom, $urandom);
      end
      begin
        for (int i = 0; i < 6; i++) get_rsp("bp");
      end
    join
    chk("bp_exec_total", exec_cnt - base, 6);

    // Randomized traffic with overlapping push/pop and random ready delays.
    rand_delay = 1'b1;
    fork
      begin
        for (int i = 0; i < 24; i++) begin
          repeat ($urandom_range(0, 2)) tick();
          push_req(1'($urandom), $urandom, $urandom);
        end
      end
      begin
        for (int i = 0; i < 24; i++) begin
          repeat ($urandom_range(0, 3)) tick();
          get_rsp("rnd");
        end
      end
    join
    rand_delay = 1'b0;

    // fin coinciding with the last watchdog cycle wins.
    fin_delay = TIMEOUT;
    push_req(1'b0, $urandom, $urandom);
    get_rsp("coincide");
    chk("coincide_errcnt", bus.err_count, err_model);

    // Timeout: fin 300 cycles after exec.
    fin_delay = 300;
    push_req(1'b0, $urandom, $urandom);
    repeat (TIMEOUT + 1) tick();
    chk("to_errcnt_before", bus.err_count, err_model);
    tick();
    err_model++;
    chk("to_errcnt_after", bus.err_count, err_model);
    repeat (30) tick();
    chk("to_no_rsp_before_fin", bus.rsp_valid, 0);
    get_rsp("timeout");
    fin_delay = 3;
    push_req(1'b1, $urandom, $urandom);
    get_rsp("after_to");

    // One cycle past the boundary gives an error.
    fin_delay = TIMEOUT + 1;
    push_req(1'b0, $urandom, $urandom);
    get_rsp("to_edge");
    err_model++;
    chk("to_edge_errcnt", bus.err_count, err_model);

    // Reset mid-WAIT with 3 entries queued, then a stray fin.
    fin_delay = 1000;
    for (int i = 0; i < 4; i++) push_req(1'($urandom), $urandom, $urandom);
    repeat (5) tick();
    abort_gen++;
    nreset = 1'b0;
    tick();
    nreset = 1'b1;
    req_q.delete();
    rsp_q.delete();
    chk_reset_vals("midrst");
    stray_gen++;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (bus.rsp_valid !== 1'b0 || bus.md_exec !== 1'b0) seen = 1'b1;
    end
    chk("stray_fin_ignored", seen, 0);
    fin_delay = 4;
    push_req(1'b0, $urandom, $urandom);
    get_rsp("post_rst");

    chk("exec_single_outstanding", exec_busy_viol, 0);
    chk("model_drained", req_q.size() + rsp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
